// File: rtl/decode_pkg.sv
// decode_pkg: shared definitions for the decode stage.
//   - opcode width and instruction field offsets (as functions of RA)
//   - branch sense encodings (BR_EQ / BR_NE)
//   - f_clog2 for deriving RA from NREG
//   - f_sext_off: sign-extends the rd field for use as a branch offset
package decode_pkg;

  localparam int OPC_W = 4;

  // Branch sense, as carried on in_br_ne
  localparam logic BR_EQ = 1'b0;
  localparam logic BR_NE = 1'b1;

  function automatic int f_clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

  // Instruction layout: {opcode, rs1, rs2, rd}, each register field RA bits
  function automatic int f_rd_lsb(input int ra);
    return 0 * ra;
  endfunction

  function automatic int f_rs2_lsb(input int ra);
    return ra;
  endfunction

  function automatic int f_rs1_lsb(input int ra);
    return 2 * ra;
  endfunction

  function automatic int f_opc_lsb(input int ra);
    return 3 * ra;
  endfunction

  // Sign-extend the low 'ra' bits of 'field' to 32 bits. Callers truncate
  // the result to their PC width, which gives modulo-2^PC_W arithmetic.
  function automatic logic [31:0] f_sext_off(input logic [31:0] field, input int ra);
    logic [31:0] mask;
    logic [31:0] r;
    mask = (32'd1 << ra) - 32'd1;
    r    = field & mask;
    if (r[ra-1]) begin
      r = r | ~mask;
    end
    return r;
  endfunction

endpackage

// File: rtl/decode_regfile.sv
// decode_regfile: NREG x DATA_W register file for the decode stage.
//   clk, reset          : clock, asynchronous active-high reset (clears all registers)
//   rd_addr_a/rd_data_a : read port A (combinational)
//   rd_addr_b/rd_data_b : read port B (combinational)
//   wr_en/wr_addr/wr_data : single write port, committed on posedge
// R0 always reads zero and ignores writes. A write in the same cycle as a
// read of the same (non-zero) register is forwarded to the read port.
module decode_regfile
  import decode_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int NREG   = 16,
  localparam int RA    = f_clog2(NREG)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [RA-1:0]     rd_addr_a,
  output logic [DATA_W-1:0] rd_data_a,
  input  logic [RA-1:0]     rd_addr_b,
  output logic [DATA_W-1:0] rd_data_b,
  input  logic              wr_en,
  input  logic [RA-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data
);

  logic [DATA_W-1:0] regs [NREG];

  // One flop group per register so the reset can clear every entry at once;
  // entry 0 is a constant and never stores anything.
  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_reg
      if (gi == 0) begin : g_zero
        assign regs[gi] = '0;
      end else begin : g_flop
        logic [DATA_W-1:0] q_reg;
        always_ff @(posedge clk or posedge reset) begin
          if (reset) begin
            q_reg <= '0;
          end else if (wr_en && (wr_addr == RA'(gi))) begin
            q_reg <= wr_data;
          end
        end
        assign regs[gi] = q_reg;
      end
    end
  endgenerate

  always_comb begin
    rd_data_a = regs[rd_addr_a];
    if (rd_addr_a == '0) begin
      rd_data_a = '0;
    end else if (wr_en && (wr_addr == rd_addr_a)) begin
      rd_data_a = wr_data;
    end
  end

  always_comb begin
    rd_data_b = regs[rd_addr_b];
    if (rd_addr_b == '0) begin
      rd_data_b = '0;
    end else if (wr_en && (wr_addr == rd_addr_b)) begin
      rd_data_b = wr_data;
    end
  end

endmodule

// File: rtl/decode_stage_pipe.sv
// decode_stage_pipe: pipelined decode stage between fetch and execute.
//   clk, reset            : clock, asynchronous active-high reset
//   in_valid/in_ready     : handshake with fetch
//   in_inst, in_pc        : instruction {opcode, rs1, rs2, rd} and its pc
//   in_wr/in_load/in_branch/in_br_ne : instruction flags
//   wb_en/wb_addr/wb_data : writeback into the register file
//   br_taken/br_target    : combinational taken-branch pulse and target
//   out_valid/out_ready   : handshake with execute
//   out_*                 : registered ID/EX fields
// Reads operands (with writeback bypass), resolves BEQ/BNE, stalls on
// load-use and branch-operand hazards, and holds the ID/EX register.
module decode_stage_pipe
  import decode_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int PC_W    = 12,
  parameter int NREG    = 16,
  localparam int RA     = f_clog2(NREG),
  localparam int INST_W = 3 * RA + 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [INST_W-1:0] in_inst,
  input  logic [PC_W-1:0]   in_pc,
  input  logic              in_wr,
  input  logic              in_load,
  input  logic              in_branch,
  input  logic              in_br_ne,
  input  logic              wb_en,
  input  logic [RA-1:0]     wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              br_taken,
  output logic [PC_W-1:0]   br_target,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [3:0]        out_opcode,
  output logic [DATA_W-1:0] out_rs1_data,
  output logic [DATA_W-1:0] out_rs2_data,
  output logic [RA-1:0]     out_rd,
  output logic [PC_W-1:0]   out_pc,
  output logic              out_wr,
  output logic              out_load
);

  localparam int OPC_LSB = f_opc_lsb(RA);
  localparam int RS1_LSB = f_rs1_lsb(RA);
  localparam int RS2_LSB = f_rs2_lsb(RA);
  localparam int RD_LSB  = f_rd_lsb(RA);

  logic [OPC_W-1:0]  opcode;
  logic [RA-1:0]     rs1;
  logic [RA-1:0]     rs2;
  logic [RA-1:0]     rd_field;
  logic [DATA_W-1:0] rs1_val;
  logic [DATA_W-1:0] rs2_val;
  logic              hz;
  logic              accept;

  logic              out_valid_reg;
  logic [OPC_W-1:0]  out_opcode_reg;
  logic [DATA_W-1:0] out_rs1_data_reg;
  logic [DATA_W-1:0] out_rs2_data_reg;
  logic [RA-1:0]     out_rd_reg;
  logic [PC_W-1:0]   out_pc_reg;
  logic              out_wr_reg;
  logic              out_load_reg;

  assign opcode   = in_inst[OPC_LSB +: OPC_W];
  assign rs1      = in_inst[RS1_LSB +: RA];
  assign rs2      = in_inst[RS2_LSB +: RA];
  assign rd_field = in_inst[RD_LSB +: RA];

  decode_regfile #(
    .DATA_W (DATA_W),
    .NREG   (NREG)
  ) u_regfile (
    .clk       (clk),
    .reset     (reset),
    .rd_addr_a (rs1),
    .rd_data_a (rs1_val),
    .rd_addr_b (rs2),
    .rd_data_b (rs2_val),
    .wr_en     (wb_en),
    .wr_addr   (wb_addr),
    .wr_data   (wb_data)
  );

  // The instruction in ID/EX produces a register this one reads, and the value
  // is not yet usable here: a load has no data until execute/memory, and a
  // branch compares in decode so it cannot wait for forwarding downstream.
  always_comb begin
    hz = out_valid_reg && out_wr_reg && (out_rd_reg != '0) &&
         ((out_rd_reg == rs1) || (out_rd_reg == rs2)) &&
         (out_load_reg || in_branch);
  end

  // reset gating keeps br_taken low while the pipe is being cleared
  assign in_ready = !reset && !hz && (!out_valid_reg || out_ready);
  assign accept   = in_valid && in_ready;

  assign br_taken  = accept && in_branch &&
                     ((rs1_val == rs2_val) ^ (in_br_ne == BR_NE));
  assign br_target = in_pc + PC_W'(1) + PC_W'(f_sext_off(32'(rd_field), RA));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_reg    <= 1'b0;
      out_opcode_reg   <= '0;
      out_rs1_data_reg <= '0;
      out_rs2_data_reg <= '0;
      out_rd_reg       <= '0;
      out_pc_reg       <= '0;
      out_wr_reg       <= 1'b0;
      out_load_reg     <= 1'b0;
    end else if (accept) begin
      out_valid_reg    <= 1'b1;
      out_opcode_reg   <= opcode;
      out_rs1_data_reg <= rs1_val;
      out_rs2_data_reg <= rs2_val;
      out_rd_reg       <= rd_field;
      out_pc_reg       <= in_pc;
      out_wr_reg       <= in_wr;
      out_load_reg     <= in_load;
    end else if (out_ready) begin
      // consumer took the op and nothing replaces it: bubble, payload kept
      out_valid_reg    <= 1'b0;
    end
  end

  assign out_valid    = out_valid_reg;
  assign out_opcode   = out_opcode_reg;
  assign out_rs1_data = out_rs1_data_reg;
  assign out_rs2_data = out_rs2_data_reg;
  assign out_rd       = out_rd_reg;
  assign out_pc       = out_pc_reg;
  assign out_wr       = out_wr_reg;
  assign out_load     = out_load_reg;

endmodule

// File: tb/tb_decode_stage_pipe.sv
module tb_decode_stage_pipe;

  localparam int DATA_W = 16;
  localparam int PC_W   = 12;
  localparam int NREG   = 16;
  localparam int RA     = 4;
  localparam int INST_W = 3 * RA + 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [INST_W-1:0] in_inst;
  logic [PC_W-1:0]   in_pc;
  logic              in_wr, in_load, in_branch, in_br_ne;
  logic              wb_en;
  logic [RA-1:0]     wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic              br_taken;
  logic [PC_W-1:0]   br_target;
  logic              out_valid;
  logic              out_ready;
  logic [3:0]        out_opcode;
  logic [DATA_W-1:0] out_rs1_data, out_rs2_data;
  logic [RA-1:0]     out_rd;
  logic [PC_W-1:0]   out_pc;
  logic              out_wr, out_load;

  always #5 clk = ~clk;

  decode_stage_pipe #(.DATA_W(DATA_W), .PC_W(PC_W), .NREG(NREG)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
    .in_wr(in_wr), .in_load(in_load), .in_branch(in_branch), .in_br_ne(in_br_ne),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .br_taken(br_taken), .br_target(br_target),
    .out_valid(out_valid), .out_ready(out_ready), .out_opcode(out_opcode),
    .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data), .out_rd(out_rd),
    .out_pc(out_pc), .out_wr(out_wr), .out_load(out_load)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [DATA_W-1:0] m_regs [NREG];
  logic              e_valid, e_wr, e_load;
  logic [3:0]        e_op;
  logic [DATA_W-1:0] e_a, e_b;
  logic [RA-1:0]     e_rd;
  logic [PC_W-1:0]   e_pc;

  task automatic model_reset();
    for (int i = 0; i < NREG; i++) m_regs[i] = '0;
    e_valid = 0; e_wr = 0; e_load = 0; e_op = 0; e_a = 0; e_b = 0; e_rd = 0; e_pc = 0;
  endtask

  // value a reader sees for register a in this cycle
  function automatic logic [DATA_W-1:0] m_read(input int a);
    if (a == 0) return '0;
    if (wb_en && int'(wb_addr) == a) return wb_data;
    return m_regs[a];
  endfunction

  // drive instruction fields
  task automatic set_inst(input int op, input int r1, input int r2, input int rd,
                          input int pc, input bit wr, input bit ld, input bit br, input bit ne);
    logic [3:0] o4, a4, b4, d4;
    o4 = 4'(op); a4 = 4'(r1); b4 = 4'(r2); d4 = 4'(rd);
    in_inst = {o4, a4, b4, d4};
    in_pc = PC_W'(pc); in_wr = wr; in_load = ld; in_branch = br; in_br_ne = ne;
  endtask

  task automatic set_wb(input bit en, input int a, input int d);
    wb_en = en; wb_addr = RA'(a); wb_data = DATA_W'(d);
  endtask

  // One clock cycle. Called just after a negedge with inputs already driven;
  // returns just after the following negedge.
  task automatic cycle();
    int r1, r2, rd, off, tgt;
    logic [DATA_W-1:0] a, b;
    bit hz, rdy, acc, tk;
    #1;
    r1 = int'(in_inst[11:8]); r2 = int'(in_inst[7:4]); rd = int'(in_inst[3:0]);
    a = m_read(r1); b = m_read(r2);
    hz  = e_valid && e_wr && e_rd != 0 && (int'(e_rd) == r1 || int'(e_rd) == r2) &&
          (e_load || in_branch);
    rdy = !hz && (!e_valid || out_ready);
    acc = in_valid && rdy;
    tk  = acc && in_branch && ((a == b) != in_br_ne);
    off = (rd >= NREG/2) ? rd - NREG : rd;
    tgt = (int'(in_pc) + 1 + off) & ((1 << PC_W) - 1);
    chk("in_ready", 32'(in_ready), 32'(rdy));
    chk("br_taken", 32'(br_taken), 32'(tk));
    if (tk) chk("br_target", 32'(br_target), 32'(tgt));
    @(posedge clk);
    if (acc) begin
      e_valid = 1; e_op = in_inst[15:12]; e_a = a; e_b = b; e_rd = RA'(rd);
      e_pc = in_pc; e_wr = in_wr; e_load = in_load;
      $display("txn pc=%03h op=%0h rs1=%0d(%04h) rs2=%0d(%04h) rd=%0d wr=%0b ld=%0b br=%0b taken=%0b",
               in_pc, in_inst[15:12], r1, a, r2, b, rd, in_wr, in_load, in_branch, tk);
    end else if (out_ready) begin
      e_valid = 0;
    end
    if (wb_en && wb_addr != 0) m_regs[wb_addr] = wb_data;
    #1;
    chk("out_valid", 32'(out_valid), 32'(e_valid));
    chk("out_opcode", 32'(out_opcode), 32'(e_op));
    chk("out_rs1_data", 32'(out_rs1_data), 32'(e_a));
    chk("out_rs2_data", 32'(out_rs2_data), 32'(e_b));
    chk("out_rd", 32'(out_rd), 32'(e_rd));
    chk("out_pc", 32'(out_pc), 32'(e_pc));
    chk("out_wr", 32'(out_wr), 32'(e_wr));
    chk("out_load", 32'(out_load), 32'(e_load));
    @(negedge clk);
  endtask

  task automatic idle();
    in_valid = 0;
    set_inst(0, 0, 0, 0, 0, 0, 0, 0, 0);
    set_wb(0, 0, 0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_valid"}, 32'(out_valid), 0);
    chk({tag, "_fields"}, 32'({out_opcode, out_rs1_data, out_rs2_data, out_rd}), 0);
    chk({tag, "_pcflags"}, 32'({out_pc, out_wr, out_load}), 0);
    chk({tag, "_br_taken"}, 32'(br_taken), 0);
  endtask

  initial begin
    reset = 1; out_ready = 1;
    idle();
    model_reset();
    #2;
    check_all_zero("reset");
    @(negedge clk); @(negedge clk);
    reset = 0;

    // wb R3=0x1234, then read rs1=3 rs2=0 rd=5
    set_wb(1, 3, 16'h1234); cycle();
    idle(); in_valid = 1; set_inst(1, 3, 0, 5, 12'h020, 1, 0, 0, 0); cycle();
    chk("plan1_rs1", 32'(out_rs1_data), 32'h1234);
    chk("plan1_rs2", 32'(out_rs2_data), 0);
    chk("plan1_rd", 32'(out_rd), 5);
    chk("plan1_valid", 32'(out_valid), 1);

    // bypass: wb R7 in the same cycle as the read
    idle(); in_valid = 1; set_inst(2, 7, 0, 6, 12'h021, 1, 0, 0, 0); set_wb(1, 7, 16'hBEEF); cycle();
    chk("bypass_r7", 32'(out_rs1_data), 32'hBEEF);
    idle(); set_wb(1, 0, 16'hFFFF); cycle();
    idle(); in_valid = 1; set_inst(3, 0, 0, 1, 12'h022, 1, 0, 0, 0); set_wb(1, 0, 16'hFFFF); cycle();
    chk("r0_zero", 32'(out_rs1_data), 0);

    // load-use: load rd=4 then reader of rs2=4
    idle(); in_valid = 1; set_inst(4, 1, 0, 4, 12'h030, 1, 1, 0, 0); cycle();
    idle(); in_valid = 1; set_inst(5, 0, 4, 2, 12'h031, 1, 0, 0, 0);
    #1; chk("lu_stall_ready", 32'(in_ready), 0);
    cycle();
    chk("lu_bubble", 32'(out_valid), 0);
    chk("lu_ready_again", 32'(in_ready), 1);
    cycle();
    chk("lu_accepted_pc", 32'(out_pc), 32'h031);

    // back-pressure for 3 cycles
    idle(); in_valid = 1; set_inst(6, 2, 3, 8, 12'h040, 1, 0, 0, 0); out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      set_inst(6, 2, 3, 8, 12'h040 + i, 1, 0, 0, 0);
      cycle();
    end
    chk("bp_held_pc", 32'(out_pc), 32'h031);
    out_ready = 1; cycle();
    chk("bp_resume_pc", 32'(out_pc), 32'h042);

    // branches: R1=R2=5
    idle(); set_wb(1, 1, 5); cycle();
    idle(); set_wb(1, 2, 5); cycle();
    idle(); cycle();
    idle(); in_valid = 1; set_inst(9, 1, 2, 14, 12'h010, 0, 0, 1, 0);
    #1; chk("beq_taken", 32'(br_taken), 1); chk("beq_target", 32'(br_target), 32'h00F);
    cycle();
    idle(); in_valid = 1; set_inst(9, 1, 2, 14, 12'h010, 0, 0, 1, 1);
    #1; chk("bne_not_taken", 32'(br_taken), 0);
    cycle();
    idle(); in_valid = 1; set_inst(9, 1, 2, 1, 12'hFFF, 0, 0, 1, 0);
    #1; chk("beq_wrap_target", 32'(br_target), 32'h001);
    cycle();

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      bit ld, br, wr;
      ld = ($urandom_range(0, 3) == 0);
      br = !ld && ($urandom_range(0, 3) == 0);
      wr = ld || (!br && $urandom_range(0, 1) == 1);
      in_valid = ($urandom_range(0, 3) != 0);
      set_inst($urandom_range(0, 15), $urandom_range(0, 5), $urandom_range(0, 5),
               $urandom_range(0, 15), $urandom_range(0, 4095), wr, ld, br, $urandom_range(0, 1));
      set_wb($urandom_range(0, 1), $urandom_range(0, 5),
             ($urandom_range(0, 3) == 0) ? 5 : $urandom_range(0, 65535));
      out_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end

    // reset mid-operation with a valid op held
    idle(); in_valid = 1; out_ready = 1; set_inst(7, 1, 2, 3, 12'h0AB, 1, 0, 0, 0); cycle();
    chk("pre_reset_valid", 32'(out_valid), 1);
    reset = 1;
    #1; check_all_zero("async_reset");
    model_reset();
    @(negedge clk);
    reset = 0;
    idle(); in_valid = 1; set_inst(8, 1, 2, 3, 12'h0AC, 1, 0, 0, 0); cycle();
    chk("post_reset_r1", 32'(out_rs1_data), 0);
    chk("post_reset_r2", 32'(out_rs2_data), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
